// File: rtl/jtag_host_ctrl.sv
// JTAG initiator: runs TLR / IR-scan / DR-scan / idle-TCK sequences on a TAP and returns captured TDO.
// Optional macro JTAG_HOST_TRST_EN: pulse jtag_trst_no low for the first 5 TCKs of INIT and of every TLR op.
module jtag_host_ctrl #(
  parameter int MaxLen        = 64,
  parameter int TckHalfPeriod = 2,
  parameter int LenW          = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  output logic              jtag_trst_no,
  input  logic              jtag_tdo_i
);
  localparam int StepW = $clog2(MaxLen + 7);
  localparam int PhW   = (TckHalfPeriod > 1) ? $clog2(TckHalfPeriod) : 1;
  localparam int IdxW  = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam logic [1:0] OpTlr = 2'd0, OpIr = 2'd1, OpDr = 2'd2, OpIdle = 2'd3;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_RESP} state_e;
  state_e state_q, state_d;

  // TCKs spent walking from RTI to the first shift TCK
  function automatic int pre_len(input logic [1:0] op);
    return (op == OpIr) ? 4 : 3;
  endfunction

  function automatic int seq_len(input logic [1:0] op, input int len);
    case (op)
      OpTlr:   return 6;
      OpIdle:  return len;
      default: return (len == 0) ? 0 : pre_len(op) + len + 2;
    endcase
  endfunction

  function automatic logic tms_at(input logic [1:0] op, input int len, input int s);
    if (op == OpTlr) return s < 5;
    if (op == OpIdle) return 1'b0;
    if (s < pre_len(op)) return (s == 0) || (op == OpIr && s == 1);
    if (s < pre_len(op) + len) return s == pre_len(op) + len - 1;
    return s == pre_len(op) + len;
  endfunction

  function automatic logic shift_at(input logic [1:0] op, input int len, input int s);
    return (op == OpIr || op == OpDr) && s >= pre_len(op) && s < pre_len(op) + len;
  endfunction

  logic [1:0]        op_q;
  logic [LenW-1:0]   len_q, len_c;
  logic [MaxLen-1:0] data_q, cap_q;
  logic [StepW-1:0]  step_q, total_q;
  logic [PhW-1:0]    ph_q;
  logic              hi_q, armed_q;
  logic              cmd_fire, rsp_fire, zero_cmd, ticking, ph_end, tail, seq_done;
  logic              tck_d, tms_d, tdi_d, trst_d, cmd_ready_d, rsp_valid_d, busy_d;
  logic [IdxW-1:0]   tdi_idx, cap_idx;
  int                len_i, step_i, nxt_i;

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;
  assign len_c    = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;
  assign zero_cmd = (cmd_op_i != OpTlr) && (len_c == '0);
  assign ticking  = (state_q == S_RUN) || (state_q == S_INIT && armed_q);
  assign ph_end   = ph_q == PhW'(TckHalfPeriod - 1);
  assign tail     = step_q == total_q;
  // the trailing low half-period after the last TCK closes the sequence
  assign seq_done = ticking && ph_end && !hi_q && tail;
  assign len_i    = int'(len_q);
  assign step_i   = int'(step_q);
  assign nxt_i    = step_i + 1;
  assign tdi_idx  = IdxW'(nxt_i - pre_len(op_q));
  assign cap_idx  = IdxW'(step_i - pre_len(op_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (seq_done) state_d = S_IDLE;
      S_IDLE:  if (cmd_fire) state_d = zero_cmd ? S_RESP : S_RUN;
      S_RUN:   if (seq_done) state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    tck_d  = jtag_tck_o;
    tms_d  = jtag_tms_o;
    tdi_d  = jtag_tdi_o;
    trst_d = jtag_trst_no;
    if (state_q == S_INIT && !armed_q) begin
      tms_d  = 1'b1;
      trst_d = 1'b0;
    end
    if (state_q == S_IDLE) begin
      tms_d = 1'b0;
      tdi_d = 1'b0;
      if (cmd_fire && !zero_cmd) begin
        tms_d  = tms_at(cmd_op_i, int'(len_c), 0);
        trst_d = (cmd_op_i != OpTlr);
      end
    end
    if (ticking && ph_end) begin
      if (!hi_q) begin
        tck_d = !tail;
      end else begin
        tck_d  = 1'b0;
        tms_d  = tms_at(op_q, len_i, nxt_i);
        tdi_d  = shift_at(op_q, len_i, nxt_i) && data_q[tdi_idx];
        trst_d = !(op_q == OpTlr && nxt_i < 5);
      end
    end
`ifndef JTAG_HOST_TRST_EN
    trst_d = 1'b1;
`endif
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jtag_tck_o   <= 1'b0;
      jtag_tms_o   <= 1'b1;
      jtag_tdi_o   <= 1'b0;
      jtag_trst_no <= 1'b1;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      busy_o       <= 1'b1;
      rsp_data_o   <= '0;
      op_q         <= OpTlr;
      len_q        <= '0;
      data_q       <= '0;
      cap_q        <= '0;
      step_q       <= '0;
      total_q      <= StepW'(6);
      ph_q         <= '0;
      hi_q         <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      jtag_tck_o   <= tck_d;
      jtag_tms_o   <= tms_d;
      jtag_tdi_o   <= tdi_d;
      jtag_trst_no <= trst_d;
      cmd_ready_o  <= cmd_ready_d;
      rsp_valid_o  <= rsp_valid_d;
      busy_o       <= busy_d;
      if (state_q == S_INIT) armed_q <= 1'b1;
      if (cmd_fire) begin
        op_q    <= cmd_op_i;
        len_q   <= len_c;
        data_q  <= cmd_data_i;
        cap_q   <= '0;
        step_q  <= '0;
        ph_q    <= '0;
        hi_q    <= 1'b0;
        total_q <= StepW'(seq_len(cmd_op_i, int'(len_c)));
      end else if (ticking) begin
        if (!ph_end) begin
          ph_q <= ph_q + 1'b1;
        end else begin
          ph_q <= '0;
          if (hi_q) begin
            hi_q   <= 1'b0;
            step_q <= step_q + 1'b1;
            if (shift_at(op_q, len_i, step_i)) cap_q[cap_idx] <= jtag_tdo_i;
          end else if (!tail) begin
            hi_q <= 1'b1;
          end
        end
      end
      if (cmd_fire || rsp_fire)             rsp_data_o <= '0;
      else if (state_q == S_RUN && seq_done) rsp_data_o <= cap_q;
    end
  end
endmodule

// File: tb/tb_jtag_host_ctrl.sv
// Randomized bench for jtag_host_ctrl: a TAP-side monitor records every TCK and a queue-based model
// rebuilds the expected TMS/TDI/TRST streams and captured data from the command alone.
module tb_jtag_host_ctrl;
  localparam int MaxLen = 64;
  localparam int Thp    = 2;
  localparam int LenW   = $clog2(MaxLen + 1);
  localparam int Bound  = (MaxLen + 12) * 2 * Thp + 50;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0]        cmd_op = '0;
  logic [LenW-1:0]   cmd_len = '0;
  logic [MaxLen-1:0] cmd_data = '0, rsp_data;
  logic              tck, tms, tdi, trst_n, tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_host_ctrl #(.MaxLen(MaxLen), .TckHalfPeriod(Thp)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .busy_o(busy),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_trst_no(trst_n), .jtag_tdo_i(tdo)
  );

  int vecs = 0, errs = 0, cyc = 0, last_rise = 0, tdo_mode = 0;
  logic q_tms[$], q_tdi[$], q_tdo[$], q_trst[$];
  int   q_rise[$];
  logic e_tms[$], e_tdi[$], e_trst[$];
  int   e_shift0 = -1, e_len = 0;

  initial forever begin @(posedge clk); cyc++; end

  // TAP side: TDO is presented at the rising edge and held through the high phase
  initial forever begin
    @(posedge tck);
    case (tdo_mode)
      0:       tdo = tdi;
      1:       tdo = 1'b1;
      default: tdo = 1'($urandom_range(0, 1));
    endcase
    q_tms.push_back(tms); q_tdi.push_back(tdi); q_trst.push_back(trst_n);
    q_tdo.push_back(tdo); q_rise.push_back(cyc);
    last_rise = cyc;
  end

  initial forever begin
    @(negedge tck);
    if (rst_n) begin
      vecs++;
      if (cyc - last_rise != Thp) begin
        errs++; $display("FAIL tck_high_width: got %0d cycles, want %0d", cyc - last_rise, Thp);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_q();
    q_tms.delete(); q_tdi.delete(); q_tdo.delete(); q_trst.delete(); q_rise.delete();
  endtask

  // Expected TAP streams derived from the JTAG state walk each op performs
  task automatic model(input int op, input int len, input logic [MaxLen-1:0] d);
    int l;
    l = (len > MaxLen) ? MaxLen : len;
    e_tms.delete(); e_tdi.delete(); e_trst.delete();
    e_shift0 = -1; e_len = 0;
    case (op)
      0: begin repeat (5) e_tms.push_back(1'b1); e_tms.push_back(1'b0); end
      3: repeat (l) e_tms.push_back(1'b0);
      default: if (l > 0) begin
        e_tms.push_back(1'b1);
        if (op == 1) e_tms.push_back(1'b1);
        e_tms.push_back(1'b0); e_tms.push_back(1'b0);
        e_shift0 = e_tms.size(); e_len = l;
        for (int i = 0; i < l; i++) e_tms.push_back(i == l - 1);
        e_tms.push_back(1'b1); e_tms.push_back(1'b0);
      end
    endcase
    for (int k = 0; k < e_tms.size(); k++) begin
      e_tdi.push_back((e_shift0 >= 0 && k >= e_shift0 && k < e_shift0 + l) ? d[k - e_shift0] : 1'b0);
`ifdef JTAG_HOST_TRST_EN
      e_trst.push_back(!(op == 0 && k < 5));
`else
      e_trst.push_back(1'b1);
`endif
    end
  endtask

  function automatic logic [MaxLen-1:0] exp_rsp();
    logic [MaxLen-1:0] r;
    r = '0;
    for (int i = 0; i < e_len; i++)
      if (e_shift0 + i < q_tdo.size()) r[i] = q_tdo[e_shift0 + i];
    return r;
  endfunction

  // 0 = match; otherwise which aspect of the TCK stream differs
  function automatic int seq_diff();
    if (q_tms.size() != e_tms.size()) return 1;
    for (int k = 0; k < q_tms.size(); k++) begin
      if (q_tms[k] !== e_tms[k])   return 2;
      if (q_tdi[k] !== e_tdi[k])   return 3;
      if (q_trst[k] !== e_trst[k]) return 4;
      if (k > 0 && q_rise[k] - q_rise[k-1] != 2 * Thp) return 5;
    end
    return 0;
  endfunction

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!cmd_ready && n < Bound) begin @(negedge clk); n++; end
    ok = cmd_ready;
  endtask

  task automatic issue(input int op, input int len, input logic [MaxLen-1:0] d, input int mode, output bit ok);
    @(negedge clk);
    wait_ready(ok);
    clear_q();
    tdo_mode = mode;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_len = LenW'(len); cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    while (!rsp_valid && lat < Bound) begin @(negedge clk); lat++; end
    ok = rsp_valid;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok; int code;
    rst_n = 1'b0; tdo_mode = 1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({tck, tms, tdi, trst_n, cmd_ready, rsp_valid, busy} !== 7'b0101001 || rsp_data !== '0) begin
      errs++; $display("FAIL reset_values: got %b/%h want 0101001/0",
        {tck, tms, tdi, trst_n, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    clear_q();
    rst_n = 1'b1;
    wait_ready(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL init_done: cmd_ready got 0 want 1"); end
    model(0, 0, '0);
    code = seq_diff();
    vecs++; if (code != 0) begin errs++; $display("FAIL init_seq: code %0d tcks %0d want code 0 tcks 6", code, q_tms.size()); end
    vecs++;
    if (busy !== 1'b0 || tck !== 1'b0 || tms !== 1'b0) begin
      errs++; $display("FAIL init_idle: busy/tck/tms got %b%b%b want 000", busy, tck, tms);
    end
  endtask

  task automatic test_dr_loop();
    bit ok, ok2; int lat, code;
    issue(2, 8, 64'hA5, 0, ok);
    wait_rsp(lat, ok2);
    vecs++; if (!ok || !ok2) begin errs++; $display("FAIL dr_handshake: ready %0d rsp %0d want 1 1", ok, ok2); end
    model(2, 8, 64'hA5);
    code = seq_diff();
    vecs++; if (code != 0 || q_tms.size() != 13) begin
      errs++; $display("FAIL dr_seq: code %0d tcks %0d want 0 13", code, q_tms.size());
    end
    vecs++; if (rsp_data !== 64'hA5) begin errs++; $display("FAIL dr_data: got %h want a5", rsp_data); end
    take_rsp();
    vecs++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL dr_release: valid/ready/busy got %b%b%b want 010", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_ir_ones();
    bit ok, ok2; int lat, code;
    issue(1, 5, 64'h11, 1, ok);
    wait_rsp(lat, ok2);
    model(1, 5, 64'h11);
    code = seq_diff();
    vecs++; if (!ok2 || code != 0 || q_tms.size() != 11) begin
      errs++; $display("FAIL ir_seq: rsp %0d code %0d tcks %0d want 1 0 11", ok2, code, q_tms.size());
    end
    vecs++; if (rsp_data !== 64'h1F) begin errs++; $display("FAIL ir_data: got %h want 1f", rsp_data); end
    take_rsp();
  endtask

  task automatic test_resp_hold();
    bit ok, ok2; int lat, bad, n0;
    logic [MaxLen-1:0] d, snap;
    d = {$urandom(), $urandom()};
    issue(2, 16, d, 2, ok);
    wait_rsp(lat, ok2);
    model(2, 16, d);
    snap = rsp_data;
    vecs++; if (!ok2 || snap !== exp_rsp()) begin errs++; $display("FAIL hold_data: got %h want %h", snap, exp_rsp()); end
    n0 = q_tms.size(); bad = 0;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = LenW'(3);
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0 || tck !== 1'b0 || busy !== 1'b1) bad++;
    end
    cmd_valid = 1'b0;
    vecs++; if (bad != 0 || q_tms.size() != n0) begin
      errs++; $display("FAIL hold_stable: bad cycles %0d extra tcks %0d want 0 0", bad, q_tms.size() - n0);
    end
    take_rsp();
    vecs++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== '0) begin
      errs++; $display("FAIL hold_release: valid/ready got %b%b data %h want 01 0", rsp_valid, cmd_ready, rsp_data);
    end
  endtask

  task automatic test_idle_zero_clamp();
    bit ok, ok2; int lat, code;
    logic [MaxLen-1:0] d;
    d = {$urandom(), $urandom()};
    issue(3, 3, d, 2, ok);
    wait_rsp(lat, ok2);
    model(3, 3, d);
    code = seq_diff();
    vecs++; if (!ok2 || code != 0 || q_tms.size() != 3 || rsp_data !== '0) begin
      errs++; $display("FAIL idle_op: code %0d tcks %0d data %h want 0 3 0", code, q_tms.size(), rsp_data);
    end
    take_rsp();
    issue(2, 0, d, 2, ok);
    wait_rsp(lat, ok2);
    vecs++; if (!ok2 || lat != 0 || q_tms.size() != 0 || rsp_data !== '0) begin
      errs++; $display("FAIL zero_len: latency %0d tcks %0d data %h want 0 0 0", lat, q_tms.size(), rsp_data);
    end
    take_rsp();
    issue(2, MaxLen + 1, d, 2, ok);
    wait_rsp(lat, ok2);
    model(2, MaxLen + 1, d);
    code = seq_diff();
    vecs++; if (!ok2 || code != 0 || q_tms.size() != MaxLen + 5) begin
      errs++; $display("FAIL clamp_seq: code %0d tcks %0d want 0 %0d", code, q_tms.size(), MaxLen + 5);
    end
    vecs++; if (rsp_data !== exp_rsp()) begin errs++; $display("FAIL clamp_data: got %h want %h", rsp_data, exp_rsp()); end
    take_rsp();
  endtask

  task automatic test_random();
    bit ok, ok2; int lat, code, op, len, sel;
    logic [MaxLen-1:0] d;
    for (int it = 0; it < 24; it++) begin
      op  = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      len = (sel == 0) ? 0 : (sel == 1) ? MaxLen + $urandom_range(0, 3) : $urandom_range(1, MaxLen);
      d   = {$urandom(), $urandom()};
      issue(op, len, d, $urandom_range(0, 2), ok);
      wait_rsp(lat, ok2);
      model(op, len, d);
      code = seq_diff();
      vecs++; if (!ok2 || code != 0) begin
        errs++; $display("FAIL rand_seq[%0d]: op %0d len %0d code %0d tcks %0d want 0 %0d",
          it, op, len, code, q_tms.size(), e_tms.size());
      end
      vecs++; if (rsp_data !== exp_rsp()) begin
        errs++; $display("FAIL rand_data[%0d]: op %0d len %0d got %h want %h", it, op, len, rsp_data, exp_rsp());
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_rsp();
      vecs++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        errs++; $display("FAIL rand_release[%0d]: ready/valid got %b%b want 10", it, cmd_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_reset_midscan();
    bit ok, seen; int n, code;
    issue(2, 8, 64'h3C, 0, ok);
    n = 0;
    while (q_tms.size() < 8 && n < Bound) begin @(negedge clk); n++; end
    vecs++; if (q_tms.size() < 8) begin errs++; $display("FAIL mid_reach: tcks %0d want 8", q_tms.size()); end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (tck !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1 || tms !== 1'b1 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL mid_reset: tck/valid/busy/tms/ready got %b%b%b%b%b want 00110",
        tck, rsp_valid, busy, tms, cmd_ready);
    end
    clear_q();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0; seen = 1'b0;
    while (!cmd_ready && n < Bound) begin
      @(negedge clk); n++;
      if (rsp_valid) seen = 1'b1;
    end
    model(0, 0, '0);
    code = seq_diff();
    vecs++; if (!cmd_ready || seen || code != 0) begin
      errs++; $display("FAIL mid_reinit: ready %b stray rsp %b code %0d want 1 0 0", cmd_ready, seen, code);
    end
  endtask

  initial begin
    test_reset();
    test_dr_loop();
    test_ir_ones();
    test_resp_hold();
    test_idle_zero_clamp();
    test_random();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
